// File: rtl/router_pkt_tx_if.sv
// Handshake and data bundle between the packet source, router_pkt_tx and the router input.
// The master modport drives requests, source data and the router stall; the slave modport is the TX block.
interface router_pkt_tx_if;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic       abort;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_busy;
  logic       done;
  logic       err;

  modport master (
    output start, dest_addr, payload_len, abort, src_valid, src_data, busy,
    input  src_ready, pkt_valid, data_out, tx_busy, done, err
  );

  modport slave (
    input  start, dest_addr, payload_len, abort, src_valid, src_data, busy,
    output src_ready, pkt_valid, data_out, tx_busy, done, err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload from upstream, then sends header, payload and an XOR parity byte.
// Every output decodes from registered state, pointers, parity or buffer contents.
module router_pkt_tx (
  input  logic             clk,
  input  logic             rst,
  router_pkt_tx_if.slave   bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_HEADER  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [5:0] len_q, len_d;
  logic [5:0] wptr_q, wptr_d;
  logic [5:0] rptr_q, rptr_d;
  logic [7:0] par_q, par_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       wr_en;
  logic [7:0] mem_q [64];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    par_d   = par_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.dest_addr != 2'd3 && bus.payload_len != 6'd0) begin
              addr_d  = bus.dest_addr;
              len_d   = bus.payload_len;
              par_d   = {bus.payload_len, bus.dest_addr};
              wptr_d  = '0;
              state_d = S_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (bus.src_valid) begin
            wr_en  = 1'b1;
            par_d  = par_q ^ bus.src_data;
            wptr_d = wptr_q + 6'd1;
            if (wptr_q == len_q - 6'd1) state_d = S_HEADER;
          end
        end
        S_HEADER: begin
          if (!bus.busy) begin
            rptr_d  = '0;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!bus.busy) begin
            rptr_d = rptr_q + 6'd1;
            if (rptr_q == len_q - 6'd1) state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          if (!bus.busy) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      par_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      par_q   <= par_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Payload storage carries no reset; stale entries are never read before being rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= bus.src_data;
  end

  always_comb begin
    bus.data_out = '0;
    case (state_q)
      S_HEADER:  bus.data_out = {len_q, addr_q};
      S_PAYLOAD: bus.data_out = mem_q[rptr_q];
      S_PARITY:  bus.data_out = par_q;
      default:   bus.data_out = '0;
    endcase
  end

  assign bus.pkt_valid = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
  assign bus.src_ready = (state_q == S_LOAD);
  assign bus.tx_busy   = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 Parameters: none; byte width fixed at 8, max payload 63 bytes.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-004 start  in  1  request to send one packet; sampled only in IDLE.
REQ-005 dest_addr  in  2  destination port 0..2; 3 is illegal.
REQ-006 payload_len  in  6  payload byte count 1..63; 0 is illegal.
REQ-007 abort  in  1  synchronous abort, returns to IDLE from any state.
REQ-008 src_valid  in  1  payload byte available on src_data.
REQ-009 src_data  in  8  payload byte from upstream.
REQ-010 src_ready  out  1  TX accepts src_data this cycle.
REQ-011 busy  in  1  router input stall; current byte must be held.
REQ-012 pkt_valid  out  1  header/payload byte valid toward router.
REQ-013 data_out  out  8  byte presented to router data_in.
REQ-014 tx_busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse after parity byte transfer.
REQ-016 err  out  1  one-cycle pulse on rejected start.

Function
REQ-017 States SHALL be IDLE, LOAD, HEADER, PAYLOAD, PARITY; outputs SHALL decode from registered state/counters/buffer only, no combinational input-to-output path except none.
REQ-018 IDLE: start=1 with dest_addr!=3 and payload_len!=0 SHALL latch addr/len, set parity reg to header {len,addr}, clear write pointer, go LOAD.
REQ-019 IDLE: start=1 with dest_addr=3 or payload_len=0 SHALL pulse err next cycle and remain IDLE.
REQ-020 LOAD: src_ready=1; each edge with src_valid=1 SHALL write src_data into 64x8 buffer at wptr, XOR into parity, increment wptr.
REQ-021 LOAD SHALL go HEADER on the edge accepting byte number len; src_valid gaps SHALL stall LOAD indefinitely.
REQ-022 HEADER: pkt_valid=1, data_out={len[5:0],addr[1:0]}; edge with busy=0 SHALL go PAYLOAD with rptr=0; busy=1 SHALL hold.
REQ-023 PAYLOAD: pkt_valid=1, data_out=buf[rptr]; edge with busy=0 increments rptr; transfer of byte len-1 SHALL go PARITY.
REQ-024 PARITY: pkt_valid=0, data_out=XOR of header and all payload bytes; edge with busy=0 SHALL go IDLE and pulse done in the following cycle.
REQ-025 busy SHALL be ignored in IDLE and LOAD; data_out and pkt_valid SHALL stay constant while busy=1.
REQ-026 In IDLE and LOAD pkt_valid=0, data_out=8'h00; src_ready=0 outside LOAD.
REQ-027 abort=1 SHALL take priority over all transitions: next state IDLE, pointers cleared, no done, no err.
REQ-028 start asserted while not IDLE SHALL be ignored (no err, no queueing).
REQ-029 With busy=0 and src_valid=1 throughout, start edge to done pulse SHALL be len+len+3 cycles (LOAD len, HEADER 1, PAYLOAD len, PARITY 1, done 1).
REQ-030 len=63 SHALL use buffer entries 0..62 with no pointer wrap; pointers SHALL be 6 bits.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, pkt_valid=0, data_out=8'h00, src_ready=0, tx_busy=0, done=0, err=0, pointers and parity cleared.
REQ-032 Reset mid-packet SHALL drop the packet with no done; buffer contents need not be cleared.
REQ-033 First start SHALL be honoured on the first rising edge after rst deasserts.

Verification
REQ-034 addr=1, len=3, bytes 11,22,33, busy=0 -> data_out 0D(pv=1),11,22,33(pv=1), then 0D^11^22^33=0D^00=0D... parity 8'h0D^8'h11^8'h22^8'h33 = 8'h0D with pv=0; done 9 cycles after start.
REQ-035 addr=0, len=2, busy=1 for 3 cycles during PAYLOAD byte 0 -> byte 0 held 4 cycles, packet otherwise unchanged, done 3 cycles late.
REQ-036 start with addr=3 len=5, then addr=2 len=0 -> err pulses twice, tx_busy stays 0, src_ready never asserts.
REQ-037 addr=2, len=63, src_valid toggling every other cycle -> LOAD lasts 125 cycles, 63 payload bytes in order, parity correct.
REQ-038 abort during PAYLOAD byte 1, then rst=0 during LOAD of a second packet -> IDLE each time, pkt_valid=0, no done; third packet sends correctly.
